// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two lanes onto one shared ALU.
// OP register drives the ALU; RES register hands off with valid/ready.
module alu_issue_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [4:0]           r0_funct,
  input  logic                 r0_alu_src,
  input  logic [DWIDTH-1:0]    r0_rs,
  input  logic [DWIDTH-1:0]    r0_rt,
  input  logic [IMM_WIDTH-1:0] r0_imm,
  input  logic [PC_WIDTH-1:0]  r0_pc,
  input  logic [TAG_WIDTH-1:0] r0_tag,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [4:0]           r1_funct,
  input  logic                 r1_alu_src,
  input  logic [DWIDTH-1:0]    r1_rs,
  input  logic [DWIDTH-1:0]    r1_rt,
  input  logic [IMM_WIDTH-1:0] r1_imm,
  input  logic [PC_WIDTH-1:0]  r1_pc,
  input  logic [TAG_WIDTH-1:0] r1_tag,
  output logic [4:0]           x_funct,
  output logic                 x_alu_src,
  output logic [DWIDTH-1:0]    x_rs,
  output logic [DWIDTH-1:0]    x_rt,
  output logic [IMM_WIDTH-1:0] x_imm,
  output logic [PC_WIDTH-1:0]  x_pc,
  input  logic [DWIDTH-1:0]    x_value,
  input  logic [PC_WIDTH-1:0]  x_pc_out,
  input  logic                 x_change_pc,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DWIDTH-1:0]    res_value,
  output logic [PC_WIDTH-1:0]  res_pc,
  output logic                 res_change_pc,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic                 res_lane
);

  typedef struct packed {
    logic [4:0]           funct;
    logic                 alu_src;
    logic [DWIDTH-1:0]    rs;
    logic [DWIDTH-1:0]    rt;
    logic [IMM_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]  pc;
    logic [TAG_WIDTH-1:0] tag;
    logic                 lane;
  } op_t;

  op_t  req0, req1, req_sel, op_q;
  logic op_valid;
  logic last_grant;
  logic grant;
  logic any_req;
  logic res_advance;
  logic op_advance;
  logic accept_en;
  logic take;

  always_comb begin
    req0 = '{funct: r0_funct, alu_src: r0_alu_src,
             rs: r0_rs, rt: r0_rt, imm: r0_imm,
             pc: r0_pc, tag: r0_tag, lane: 1'b0};
    req1 = '{funct: r1_funct, alu_src: r1_alu_src,
             rs: r1_rs, rt: r1_rt, imm: r1_imm,
             pc: r1_pc, tag: r1_tag, lane: 1'b1};
  end

  always_comb begin
    grant   = 1'b0;
    any_req = 1'b0;
    unique case (1'b1)
      r0_valid & r1_valid: begin
        any_req = 1'b1;
        grant   = ~last_grant;
      end
      r0_valid & ~r1_valid: begin
        any_req = 1'b1;
        grant   = 1'b0;
      end
      ~r0_valid & r1_valid: begin
        any_req = 1'b1;
        grant   = 1'b1;
      end
      default: ;
    endcase
  end

  assign res_advance = ~res_valid | res_ready;
  assign op_advance  = op_valid & res_advance;
  // rst_n gates acceptance so no handshake is seen while held in reset
  assign accept_en   = rst_n & ~flush & (~op_valid | op_advance);
  assign take        = accept_en & any_req;
  assign r0_ready    = take & ~grant;
  assign r1_ready    = take & grant;
  assign req_sel     = grant ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      op_valid   <= 1'b0;
      last_grant <= 1'b1;
    end else if (flush) begin
      op_valid <= 1'b0;
    end else if (take) begin
      op_q       <= req_sel;
      op_valid   <= 1'b1;
      last_grant <= grant;
    end else if (op_advance) begin
      op_valid <= 1'b0;
    end
  end

  assign x_funct   = op_q.funct;
  assign x_alu_src = op_q.alu_src;
  assign x_rs      = op_q.rs;
  assign x_rt      = op_q.rt;
  assign x_imm     = op_q.imm;
  assign x_pc      = op_q.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid     <= 1'b0;
      res_value     <= '0;
      res_pc        <= '0;
      res_change_pc <= 1'b0;
      res_tag       <= '0;
      res_lane      <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (op_advance) begin
      res_valid     <= 1'b1;
      res_value     <= x_value;
      res_pc        <= x_pc_out;
      res_change_pc <= x_change_pc;
      res_tag       <= op_q.tag;
      res_lane      <= op_q.lane;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter with a behavioural ALU stub.
// Expected results are queued at accept and compared at RES handshake.
module tb_alu_issue_arbiter;
  localparam int DW = 32;
  localparam int PW = 32;
  localparam int IW = 16;
  localparam int TW = 4;

  typedef logic [DW+PW+1+TW+1-1:0] exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, flush;
  logic          r0_valid, r0_ready, r0_alu_src;
  logic [4:0]    r0_funct;
  logic [DW-1:0] r0_rs, r0_rt;
  logic [IW-1:0] r0_imm;
  logic [PW-1:0] r0_pc;
  logic [TW-1:0] r0_tag;
  logic          r1_valid, r1_ready, r1_alu_src;
  logic [4:0]    r1_funct;
  logic [DW-1:0] r1_rs, r1_rt;
  logic [IW-1:0] r1_imm;
  logic [PW-1:0] r1_pc;
  logic [TW-1:0] r1_tag;
  logic [4:0]    x_funct;
  logic          x_alu_src;
  logic [DW-1:0] x_rs, x_rt, x_value;
  logic [IW-1:0] x_imm;
  logic [PW-1:0] x_pc, x_pc_out;
  logic          x_change_pc;
  logic          res_valid, res_ready, res_change_pc, res_lane;
  logic [DW-1:0] res_value;
  logic [PW-1:0] res_pc;
  logic [TW-1:0] res_tag;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   grants[$];
  int   pops = 0;
  int   pushes = 0;
  bit   acc0, acc1, auto0, auto1;

  alu_issue_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .r0_valid(r0_valid), .r0_ready(r0_ready),
    .r0_funct(r0_funct), .r0_alu_src(r0_alu_src),
    .r0_rs(r0_rs), .r0_rt(r0_rt), .r0_imm(r0_imm),
    .r0_pc(r0_pc), .r0_tag(r0_tag),
    .r1_valid(r1_valid), .r1_ready(r1_ready),
    .r1_funct(r1_funct), .r1_alu_src(r1_alu_src),
    .r1_rs(r1_rs), .r1_rt(r1_rt), .r1_imm(r1_imm),
    .r1_pc(r1_pc), .r1_tag(r1_tag),
    .x_funct(x_funct), .x_alu_src(x_alu_src),
    .x_rs(x_rs), .x_rt(x_rt), .x_imm(x_imm), .x_pc(x_pc),
    .x_value(x_value), .x_pc_out(x_pc_out),
    .x_change_pc(x_change_pc),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_pc(res_pc),
    .res_change_pc(res_change_pc), .res_tag(res_tag),
    .res_lane(res_lane)
  );

  function automatic logic [DW-1:0] alu_val(
    logic [4:0] f, logic s, logic [DW-1:0] a,
    logic [DW-1:0] t, logic [IW-1:0] imm);
    logic [DW-1:0] b;
    b = s ? {{(DW-IW){imm[IW-1]}}, imm} : t;
    case (f)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd19:   return '0;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [PW-1:0] pc_tgt(
    logic [4:0] f, logic [DW-1:0] a, logic [PW-1:0] pc);
    return (f == 5'd19) ? a : pc + 4;
  endfunction

  assign x_value     = alu_val(x_funct, x_alu_src, x_rs, x_rt, x_imm);
  assign x_pc_out    = pc_tgt(x_funct, x_rs, x_pc);
  assign x_change_pc = (x_funct == 5'd19);

  function automatic exp_t mk(
    logic [4:0] f, logic s, logic [DW-1:0] a, logic [DW-1:0] t,
    logic [IW-1:0] imm, logic [PW-1:0] pc, logic [TW-1:0] tag,
    logic lane);
    return {alu_val(f, s, a, t, imm), pc_tgt(f, a, pc),
            (f == 5'd19), tag, lane};
  endfunction

  task automatic check(string tag, logic [127:0] got,
                       logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst_n) begin
      if (r0_valid && r1_valid)
        check("one_ready", r0_ready & r1_ready, 0);
      if (flush) begin
        sb.delete();
      end else begin
        if (res_valid && res_ready) begin
          if (sb.size() == 0) check("sb_extra", 1, 0);
          else check("sb", {res_value, res_pc, res_change_pc,
                            res_tag, res_lane}, sb.pop_front());
          pops++;
        end
        if (r0_valid && r0_ready) begin
          sb.push_back(mk(r0_funct, r0_alu_src, r0_rs, r0_rt,
                          r0_imm, r0_pc, r0_tag, 1'b0));
          grants.push_back(0);
          pushes++;
          acc0 = 1'b1;
        end
        if (r1_valid && r1_ready) begin
          sb.push_back(mk(r1_funct, r1_alu_src, r1_rs, r1_rt,
                          r1_imm, r1_pc, r1_tag, 1'b1));
          grants.push_back(1);
          pushes++;
          acc1 = 1'b1;
        end
      end
    end
  end

  task automatic set_req(int l, logic [4:0] f, logic s,
    logic [DW-1:0] a, logic [DW-1:0] t, logic [IW-1:0] imm,
    logic [PW-1:0] pc, logic [TW-1:0] tag);
    if (l == 0) begin
      r0_funct = f; r0_alu_src = s; r0_rs = a; r0_rt = t;
      r0_imm = imm; r0_pc = pc; r0_tag = tag; r0_valid = 1'b1;
    end else begin
      r1_funct = f; r1_alu_src = s; r1_rs = a; r1_rt = t;
      r1_imm = imm; r1_pc = pc; r1_tag = tag; r1_valid = 1'b1;
    end
  endtask

  task automatic gen(int l);
    int unsigned k;
    logic [4:0] f;
    k = $urandom_range(0, 5);
    f = (k == 5) ? 5'd19 : 5'(k);
    set_req(l, f, 1'($urandom), $urandom, $urandom,
            IW'($urandom), $urandom, TW'($urandom));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (acc0) begin
      if (auto0) gen(0);
      else r0_valid = 1'b0;
    end
    if (acc1) begin
      if (auto1) gen(1);
      else r1_valid = 1'b0;
    end
  endtask

  task automatic check_alt(string tag);
    for (int i = 1; i < grants.size(); i++)
      check(tag, grants[i], 1 - grants[i-1]);
  endtask

  logic [DW-1:0] sv_val, sv_x;
  int p0;

  initial begin
    rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1;
    auto0 = 1'b0; auto1 = 1'b0;
    r0_valid = 1'b0; r1_valid = 1'b0;
    set_req(1, 0, 0, 0, 0, 0, 0, 0);
    r1_valid = 1'b0;
    set_req(0, 5'd0, 1'b0, 32'd5, 32'd7, 16'd0, 32'h100, 4'd3);

    repeat (2) @(negedge clk);
    check("rst_r0_ready", r0_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_x_rs", x_rs, 0);
    check("rst_res_value", res_value, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("first_grant", r0_ready, 1);
    step();
    @(negedge clk);
    check("x_rs", x_rs, 5);
    check("lat_res0", res_valid, 0);
    step();
    @(negedge clk);
    check("res_valid", res_valid, 1);
    check("res_value", res_value, 12);
    check("res_tag", res_tag, 3);
    check("res_lane", res_lane, 0);
    step();

    set_req(1, 5'd19, 1'b0, 32'h400, 32'd0, 16'd0, 32'h80, 4'd5);
    @(negedge clk);
    check("jr_grant", r1_ready, 1);
    step();
    step();
    @(negedge clk);
    check("jr_change", res_change_pc, 1);
    check("jr_pc", res_pc, 32'h400);
    check("jr_value", res_value, 0);
    check("jr_lane", res_lane, 1);
    step();

    grants.delete();
    p0 = pops;
    auto0 = 1'b1; auto1 = 1'b1;
    gen(0); gen(1);
    repeat (6) step();
    check("fair_n", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++)
      check("fair_grant", grants[i], i % 2);
    check("fair_thru", pops - p0, 4);
    auto0 = 1'b0; auto1 = 1'b0;
    repeat (5) step();
    check("fair_drain", sb.size(), 0);

    grants.delete();
    auto0 = 1'b1; auto1 = 1'b1;
    gen(0); gen(1);
    repeat (3) step();
    res_ready = 1'b0;
    @(negedge clk);
    check("bp_ready", r0_ready | r1_ready, 0);
    sv_val = res_value;
    sv_x = x_rs;
    repeat (2) begin
      step();
      @(negedge clk);
      check("bp_ready", r0_ready | r1_ready, 0);
      check("bp_res", res_value, sv_val);
      check("bp_x", x_rs, sv_x);
      check("bp_valid", res_valid, 1);
    end
    step();
    res_ready = 1'b1;
    repeat (4) step();
    auto0 = 1'b0; auto1 = 1'b0;
    repeat (5) step();
    check("bp_drain", sb.size(), 0);
    check("bp_count", pops, pushes);
    check_alt("bp_alt");

    grants.delete();
    auto0 = 1'b1; auto1 = 1'b1;
    gen(0); gen(1);
    repeat (3) step();
    flush = 1'b1;
    @(negedge clk);
    check("fl_noacc", r0_ready | r1_ready, 0);
    check("fl_pre", res_valid, 1);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("fl_res", res_valid, 0);
    check("fl_acc", r0_ready | r1_ready, 1);
    step();
    @(negedge clk);
    check("fl_lat1", res_valid, 0);
    step();
    @(negedge clk);
    check("fl_lat2", res_valid, 1);
    auto0 = 1'b0; auto1 = 1'b0;
    repeat (6) step();
    check("fl_drain", sb.size(), 0);
    check_alt("fl_alt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
